// File: rtl/add_step2_stage.sv
// FP add step 2: signed-magnitude add/subtract of aligned fractions, registered behind a 2-entry skid buffer.
// Define ADD_STEP2_BYPASS_EN to let an idle, unstalled stage pass the result through combinationally.
module add_step2_stage #(
  parameter int FRAC_W = 26,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic              sign1,
  input  logic              sign2,
  input  logic [EXP_W-1:0]  exponent_max_in,
  input  logic [FRAC_W-1:0] frac1,
  input  logic [FRAC_W-1:0] frac2,
  input  logic [2:0]        frm_in,
  input  logic              ovf_in,
  input  logic              unf_in,
  input  logic              dz_in,
  input  logic              inv_in,
  output logic              valid_out,
  input  logic              ready_in,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exponent_max_out,
  output logic [FRAC_W-1:0] frac_out,
  output logic              carry_out,
  output logic [2:0]        frm_out,
  output logic              ovf_out,
  output logic              unf_out,
  output logic              dz_out,
  output logic              inv_out
);

  localparam int PW = 1 + EXP_W + 1 + FRAC_W + 3 + 4;

  logic [FRAC_W:0]   sum_full;
  logic              res_sign;
  logic              res_carry;
  logic [FRAC_W-1:0] res_frac;
  logic [PW-1:0]     in_payload;
  logic [PW-1:0]     out_payload;

  logic [PW-1:0] main_reg, main_next;
  logic [PW-1:0] skid_reg, skid_next;
  logic [1:0]    count_reg, count_next;

  logic bypass;
  logic accept_store;
  logic emit_stored;

  assign sum_full = {1'b0, frac1} + {1'b0, frac2};

  always_comb begin
    res_sign  = sign1;
    res_carry = sum_full[FRAC_W];
    res_frac  = sum_full[FRAC_W-1:0];
    if (sign1 != sign2) begin
      res_carry = 1'b0;
      if (frac1 > frac2) begin
        res_frac = frac1 - frac2;
        res_sign = sign1;
      end else if (frac2 > frac1) begin
        res_frac = frac2 - frac1;
        res_sign = sign2;
      end else begin
        // Exact cancellation yields -0 only when rounding down.
        res_frac = '0;
        res_sign = (frm_in == 3'b010);
      end
    end
  end

  assign in_payload = {res_sign, exponent_max_in, res_carry, res_frac,
                       frm_in, ovf_in, unf_in, dz_in, inv_in};

`ifdef ADD_STEP2_BYPASS_EN
  assign bypass = (count_reg == 2'd0) && valid_in && ready_in;
`else
  assign bypass = 1'b0;
`endif

  // ready_out comes only from registered state, never from ready_in.
  assign ready_out    = (count_reg != 2'd2);
  assign accept_store = valid_in && ready_out && !bypass;
  assign emit_stored  = (count_reg != 2'd0) && ready_in;

  always_comb begin
    main_next  = main_reg;
    skid_next  = skid_reg;
    count_next = count_reg;
    case (count_reg)
      2'd0: begin
        if (accept_store) begin
          main_next  = in_payload;
          count_next = 2'd1;
        end
      end
      2'd1: begin
        if (accept_store && emit_stored) begin
          main_next = in_payload;
        end else if (accept_store) begin
          skid_next  = in_payload;
          count_next = 2'd2;
        end else if (emit_stored) begin
          count_next = 2'd0;
        end
      end
      2'd2: begin
        if (emit_stored) begin
          main_next  = skid_reg;
          count_next = 2'd1;
        end
      end
      default: count_next = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_reg  <= '0;
      skid_reg  <= '0;
      count_reg <= 2'd0;
    end else begin
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      count_reg <= count_next;
    end
  end

  assign valid_out   = bypass || (count_reg != 2'd0);
  assign out_payload = bypass ? in_payload : main_reg;

  assign {sign_out, exponent_max_out, carry_out, frac_out,
          frm_out, ovf_out, unf_out, dz_out, inv_out} = out_payload;

endmodule
